ad5592r_spi_responder: RTL and testbench

// - Synthesizable SPI responder that models the AD5592R from the device side of the SYNC/SCLK/SDI/SDO link.
// - It oversamples the master's SPI lines on the system clock and decodes 16-bit control-register writes.
// - After a sequence-register write, it returns 12-bit ADC results one frame later, in channel-mask order.
// - Used as an in-FPGA stand-in for the ADC during bring-up, and as a loopback target for the ADC SPI master.

---
 rtl/ad5592r_spi_responder.sv | 192 +++++++++++++++++++
 tb/tb_ad5592r_spi_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ad5592r_spi_responder.sv
// ad5592r_spi_responder: AD5592R device-side SPI model with register decode and ADC sequencer
module ad5592r_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              SYNC1,
  input  logic              SDI1,
  output logic              SDO1,
  output logic [2:0]        CH_SEL,
  input  logic [DATA_W-1:0] CH_DATA,
  output logic [7:0]        PIN_CFG,
  output logic [10:0]       GP_CTRL,
  output logic [7:0]        SEQ_MASK,
  output logic              SEQ_REP,
  output logic [15:0]       RX_WORD,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);
  typedef enum logic [1:0] {IDLE, SHIFT, DECODE, CONVERT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_s_q, sclk_s_d, sync_s_q, sync_s_d, sdi_s_q, sdi_s_d;
  logic sclk_p_q, sclk_p_d, sync_p_q, sync_p_d;
  logic [15:0] rx_q, rx_d, tx_q, tx_d, sh_q, sh_d, rx_word_q, rx_word_d;
  logic [4:0] cnt_q, cnt_d;
  logic sdo_q, sdo_d, pend_q, pend_d, done_q, done_d, err_q, err_d;
  logic [7:0] pin_q, pin_d, mask_q, mask_d;
  logic [10:0] gp_q, gp_d;
  logic rep_q, rep_d, act_q, act_d;
  logic [2:0] ch_q, ch_d;
  logic sclk_v, sync_v, sdi_v, sclk_rise, sclk_fall, sync_rise, sync_fall;
  logic [3:0] lo_first, nxt, wrap;
  // Returns the lowest set mask bit at or above lo; bit 3 set means none found.
  function automatic logic [3:0] first_at(input logic [7:0] m, input logic [3:0] lo);
    logic [3:0] r;
    r = 4'h8;
    for (int i = 7; i >= 0; i--)
      if (m[i] && 4'(i) >= lo) r = 4'(i);
    return r;
  endfunction
  assign sclk_v    = sclk_s_q[SYNC_STAGES-1];
  assign sync_v    = sync_s_q[SYNC_STAGES-1];
  assign sdi_v     = sdi_s_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_v & ~sclk_p_q;
  assign sclk_fall = ~sclk_v & sclk_p_q;
  assign sync_rise = sync_v & ~sync_p_q;
  assign sync_fall = ~sync_v & sync_p_q;
  assign lo_first  = first_at(rx_q[7:0], 4'd0);
  assign nxt       = first_at(mask_q, {1'b0, ch_q} + 4'd1);
  assign wrap      = first_at(mask_q, 4'd0);
  always_comb begin
    state_d   = state_q;
    sclk_s_d  = {sclk_s_q[SYNC_STAGES-2:0], SCLK};
    sync_s_d  = {sync_s_q[SYNC_STAGES-2:0], SYNC1};
    sdi_s_d   = {sdi_s_q[SYNC_STAGES-2:0], SDI1};
    sclk_p_d  = sclk_v;
    sync_p_d  = sync_v;
    rx_d      = rx_q;
    tx_d      = tx_q;
    sh_d      = sh_q;
    rx_word_d = rx_word_q;
    cnt_d     = cnt_q;
    sdo_d     = sdo_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pin_d     = pin_q;
    gp_d      = gp_q;
    mask_d    = mask_q;
    rep_d     = rep_q;
    act_d     = act_q;
    ch_d      = ch_q;
    case (state_q)
      IDLE: if (sync_fall || pend_q) begin
        state_d = SHIFT;
        cnt_d   = 5'd0;
        pend_d  = 1'b0;
        sdo_d   = tx_q[15];
        sh_d    = {tx_q[14:0], 1'b0};
      end
      SHIFT: if (sync_rise) begin
        sdo_d   = 1'b0;
        state_d = cnt_q == 5'd16 ? DECODE : IDLE;
        err_d   = cnt_q != 5'd16;
      end else begin
        if (sclk_fall && cnt_q != 5'd16) begin
          rx_d  = {rx_q[14:0], sdi_v};
          cnt_d = cnt_q + 5'd1;
        end
        if (sclk_rise) begin
          sdo_d = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
        end
      end
      DECODE: begin
        pend_d    = pend_q | sync_fall;
        rx_word_d = rx_q;
        done_d    = 1'b1;
        state_d   = CONVERT;
        if (!rx_q[15]) begin
          case (rx_q[14:11])
            4'b0010: begin
              mask_d = rx_q[7:0];
              rep_d  = rx_q[9];
              act_d  = |rx_q[7:0];
              ch_d   = lo_first[2:0];
            end
            4'b0011: gp_d = rx_q[10:0];
            4'b0100: pin_d = rx_q[7:0];
            4'b1111: if (rx_q[10:0] == 11'h5AC) begin
              pin_d  = 8'd0;
              gp_d   = 11'd0;
              mask_d = 8'd0;
              rep_d  = 1'b0;
              act_d  = 1'b0;
              ch_d   = 3'd0;
            end
            default: ;
          endcase
        end
      end
      CONVERT: begin
        pend_d  = pend_q | sync_fall;
        state_d = IDLE;
        tx_d    = act_q ? {1'b0, ch_q, CH_DATA} : 16'd0;
        if (act_q) begin
          ch_d  = !nxt[3] ? nxt[2:0] : wrap[2:0];
          act_d = !nxt[3] || rep_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sclk_s_q  <= '0;
      sync_s_q  <= '0;
      sdi_s_q   <= '0;
      sclk_p_q  <= 1'b0;
      sync_p_q  <= 1'b0;
      rx_q      <= 16'd0;
      tx_q      <= 16'd0;
      sh_q      <= 16'd0;
      rx_word_q <= 16'd0;
      cnt_q     <= 5'd0;
      sdo_q     <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pin_q     <= 8'd0;
      gp_q      <= 11'd0;
      mask_q    <= 8'd0;
      rep_q     <= 1'b0;
      act_q     <= 1'b0;
      ch_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      sclk_s_q  <= sclk_s_d;
      sync_s_q  <= sync_s_d;
      sdi_s_q   <= sdi_s_d;
      sclk_p_q  <= sclk_p_d;
      sync_p_q  <= sync_p_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      sh_q      <= sh_d;
      rx_word_q <= rx_word_d;
      cnt_q     <= cnt_d;
      sdo_q     <= sdo_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      err_q     <= err_d;
      pin_q     <= pin_d;
      gp_q      <= gp_d;
      mask_q    <= mask_d;
      rep_q     <= rep_d;
      act_q     <= act_d;
      ch_q      <= ch_d;
    end
  end
  assign SDO1       = sdo_q;
  assign CH_SEL     = ch_q;
  assign PIN_CFG    = pin_q;
  assign GP_CTRL    = gp_q;
  assign SEQ_MASK   = mask_q;
  assign SEQ_REP    = rep_q;
  assign RX_WORD    = rx_word_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
endmodule

// File: tb/tb_ad5592r_spi_responder.sv
// tb_ad5592r_spi_responder: directed table, corner sequences and random frames vs a reference model
module tb_ad5592r_spi_responder;
  logic CLK = 1'b0, RST = 1'b1, SCLK = 1'b1, SYNC1 = 1'b1, SDI1 = 1'b0;
  logic SDO1, SEQ_REP, FRAME_DONE, FRAME_ERR;
  logic [2:0] CH_SEL;
  logic [11:0] CH_DATA;
  logic [7:0] PIN_CFG, SEQ_MASK;
  logic [10:0] GP_CTRL;
  logic [15:0] RX_WORD;
  logic [11:0] data_tab [8];
  int total = 0, bad = 0, n_done = 0, n_err = 0;
  localparam int HALF = 8;
  ad5592r_spi_responder dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .SYNC1(SYNC1), .SDI1(SDI1), .SDO1(SDO1),
    .CH_SEL(CH_SEL), .CH_DATA(CH_DATA), .PIN_CFG(PIN_CFG), .GP_CTRL(GP_CTRL),
    .SEQ_MASK(SEQ_MASK), .SEQ_REP(SEQ_REP), .RX_WORD(RX_WORD),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );
  assign CH_DATA = data_tab[CH_SEL];
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (FRAME_DONE) n_done++;
    if (FRAME_ERR) n_err++;
  end
  typedef struct {
    logic [15:0] mosi;
    logic [15:0] miso;
    logic [7:0]  pin;
    logic [10:0] gp;
    logic [7:0]  mask;
    logic        rep;
  } vec_t;
  vec_t tbl [20];
  // Reference model: registers plus an explicit list of enabled channels walked by index
  logic [7:0] m_pin, m_mask;
  logic [10:0] m_gp;
  logic m_rep, m_act;
  logic [15:0] m_tx;
  int m_order [$];
  int m_idx;
  task automatic model_reset;
    m_pin = 0; m_gp = 0; m_mask = 0; m_rep = 0; m_act = 0; m_tx = 0; m_idx = 0;
    m_order.delete();
  endtask
  task automatic model_frame(input logic [15:0] w);
    if (!w[15]) begin
      if (w[14:11] == 4'b0010) begin
        m_mask = w[7:0];
        m_rep = w[9];
        m_order.delete();
        for (int i = 0; i < 8; i++) if (m_mask[i]) m_order.push_back(i);
        m_idx = 0;
        m_act = m_order.size() != 0;
      end else if (w[14:11] == 4'b0011) m_gp = w[10:0];
      else if (w[14:11] == 4'b0100) m_pin = w[7:0];
      else if (w[14:11] == 4'b1111 && w[10:0] == 11'h5AC) begin
        m_pin = 0; m_gp = 0; m_mask = 0; m_rep = 0; m_act = 0;
      end
    end
    if (m_act) begin
      m_tx = {1'b0, 3'(m_order[m_idx]), data_tab[m_order[m_idx]]};
      m_idx++;
      if (m_idx == m_order.size()) begin
        if (m_rep) m_idx = 0;
        else m_act = 0;
      end
    end else m_tx = 0;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic start_frame;
    wait_clk(HALF);
    SYNC1 = 1'b0;
    wait_clk(HALF);
  endtask
  task automatic xfer_bit(input logic b, output logic o);
    SDI1 = b;
    wait_clk(HALF);
    o = SDO1;
    SCLK = 1'b0;
    wait_clk(HALF);
    SCLK = 1'b1;
  endtask
  task automatic end_frame;
    wait_clk(HALF);
    SYNC1 = 1'b1;
    wait_clk(12);
  endtask
  task automatic frame(input logic [15:0] w, output logic [15:0] miso);
    logic o;
    start_frame();
    for (int i = 15; i >= 0; i--) begin
      xfer_bit(w[i], o);
      miso[i] = o;
    end
    end_frame();
  endtask
  task automatic do_reset;
    RST = 1'b1;
    wait_clk(4);
    RST = 1'b0;
    wait_clk(4);
  endtask
  initial begin
    logic [15:0] miso, w;
    logic o;
    int d0, e0;
    for (int i = 0; i < 8; i++) data_tab[i] = 12'h100 + 12'(i);
    tbl[0] = '{16'h20FF, 16'h0000, 8'hFF, 11'h000, 8'h00, 1'b0};
    tbl[1] = '{16'h19A0, 16'h0000, 8'hFF, 11'h1A0, 8'h00, 1'b0};
    tbl[2] = '{16'h12FF, 16'h0000, 8'hFF, 11'h1A0, 8'hFF, 1'b1};
    for (int i = 0; i < 9; i++)
      tbl[3+i] = '{16'h0000, {1'b0, 3'(i % 8), 12'h100 + 12'(i % 8)}, 8'hFF, 11'h1A0, 8'hFF, 1'b1};
    tbl[12] = '{16'h1085, 16'h1101, 8'hFF, 11'h1A0, 8'h85, 1'b0};
    tbl[13] = '{16'h0000, 16'h0100, 8'hFF, 11'h1A0, 8'h85, 1'b0};
    tbl[14] = '{16'h0000, 16'h2102, 8'hFF, 11'h1A0, 8'h85, 1'b0};
    tbl[15] = '{16'h0000, 16'h7107, 8'hFF, 11'h1A0, 8'h85, 1'b0};
    tbl[16] = '{16'h0000, 16'h0000, 8'hFF, 11'h1A0, 8'h85, 1'b0};
    tbl[17] = '{16'h12FF, 16'h0000, 8'hFF, 11'h1A0, 8'hFF, 1'b1};
    tbl[18] = '{16'h7DAC, 16'h0100, 8'h00, 11'h000, 8'h00, 1'b0};
    tbl[19] = '{16'h0000, 16'h0000, 8'h00, 11'h000, 8'h00, 1'b0};
    wait_clk(5);
    check("reset_sdo", 32'(SDO1), 0);
    check("reset_chsel", 32'(CH_SEL), 0);
    check("reset_regs", {PIN_CFG, GP_CTRL, SEQ_MASK, SEQ_REP}, 0);
    check("reset_rxword", 32'(RX_WORD), 0);
    check("reset_pulses", {FRAME_DONE, FRAME_ERR}, 0);
    RST = 1'b0;
    wait_clk(4);
    for (int k = 0; k < 20; k++) begin
      d0 = n_done;
      frame(tbl[k].mosi, miso);
      check($sformatf("tbl%0d_miso", k), 32'(miso), 32'(tbl[k].miso));
      check($sformatf("tbl%0d_regs", k), {PIN_CFG, GP_CTRL, SEQ_MASK, SEQ_REP},
            {tbl[k].pin, tbl[k].gp, tbl[k].mask, tbl[k].rep});
      check($sformatf("tbl%0d_rx", k), 32'(RX_WORD), 32'(tbl[k].mosi));
      check($sformatf("tbl%0d_done", k), n_done - d0, 1);
    end
    // Short frame: error pulse, no decode, then a good frame recovers
    frame(16'h2011, miso);
    check("pin_pre_err", 32'(PIN_CFG), 32'h11);
    d0 = n_done; e0 = n_err;
    w = 16'h2055;
    start_frame();
    for (int i = 15; i >= 7; i--) xfer_bit(w[i], o);
    end_frame();
    check("short_err", n_err - e0, 1);
    check("short_nodone", n_done - d0, 0);
    check("short_pin", 32'(PIN_CFG), 32'h11);
    frame(16'h2055, miso);
    check("recover_pin", 32'(PIN_CFG), 32'h55);
    check("recover_done", n_done - d0, 1);
    check("recover_noerr", n_err - e0, 1);
    // Reset mid-frame while a nonzero word is being shifted out
    frame(16'h12FF, miso);
    frame(16'h0000, miso);
    check("pre_rst_miso", 32'(miso), 32'h0100);
    d0 = n_done; e0 = n_err;
    start_frame();
    for (int i = 0; i < 7; i++) xfer_bit(1'b0, o);
    wait_clk(HALF);
    check("pre_rst_sdo", 32'(SDO1), 1);
    RST = 1'b1;
    wait_clk(3);
    check("rst_sdo", 32'(SDO1), 0);
    check("rst_regs", {CH_SEL, PIN_CFG, GP_CTRL, SEQ_MASK, SEQ_REP}, 0);
    check("rst_rxword", 32'(RX_WORD), 0);
    SYNC1 = 1'b1;
    wait_clk(4);
    RST = 1'b0;
    wait_clk(12);
    check("rst_no_pulses", (n_done - d0) + (n_err - e0), 0);
    frame(16'h12FF, miso);
    check("post_rst_seq_miso", 32'(miso), 0);
    frame(16'h0000, miso);
    check("post_rst_ch0", 32'(miso), 32'h0100);
    // Random frames against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 8; i++) data_tab[i] = 12'($urandom);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: w = {5'b00010, 11'($urandom)};
        3:       w = {5'b00100, 11'($urandom)};
        4:       w = {5'b00011, 11'($urandom)};
        5:       w = {1'b1, 15'($urandom)};
        6:       w = 16'h7DAC;
        7:       w = 16'($urandom);
        default: w = 16'h0000;
      endcase
      d0 = n_done;
      frame(w, miso);
      check($sformatf("rnd%0d_miso w=%h", k, w), 32'(miso), 32'(m_tx));
      model_frame(w);
      check($sformatf("rnd%0d_regs", k), {PIN_CFG, GP_CTRL, SEQ_MASK, SEQ_REP},
            {m_pin, m_gp, m_mask, m_rep});
      check($sformatf("rnd%0d_rx", k), 32'(RX_WORD), 32'(w));
      check($sformatf("rnd%0d_done", k), n_done - d0, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
